// File: rtl/ahb_gpio_ctrl.sv
// AHB-Lite GPIO slave: debounced buttons, LED output register, edge IRQ.
// Latency: zero-wait-state bus; input edge to IN change is 2+DEB_CYCLES cycles.
// Backpressure: none; HREADYOUT is tied high and every transfer completes OKAY.
// Optional build macro GPIO_LONGPRESS_EN adds per-channel long-press status at 0x1C.
module ahb_gpio_ctrl #(
    parameter int N_IN        = 5,
    parameter int N_OUT       = 16,
    parameter int DEB_CYCLES  = 1000000,
    parameter int DEB_W       = 20,
    parameter int LONG_CYCLES = 100000000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    input  logic [N_IN-1:0]   gpio_in,
    output logic [N_OUT-1:0]  gpio_out,
    output logic              irq
);

    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    localparam logic [5:0] A_IN   = 6'h00;
    localparam logic [5:0] A_OUT  = 6'h01;
    localparam logic [5:0] A_SET  = 6'h02;
    localparam logic [5:0] A_CLR  = 6'h03;
    localparam logic [5:0] A_TGL  = 6'h04;
    localparam logic [5:0] A_EN   = 6'h05;
    localparam logic [5:0] A_STAT = 6'h06;
`ifdef GPIO_LONGPRESS_EN
    localparam logic [5:0] A_LONG = 6'h07;
`endif

    logic [N_IN-1:0]  sync1;
    logic [N_IN-1:0]  sync2;
    logic [N_IN-1:0]  stable;
    logic [N_IN-1:0]  stable_d;
    logic [N_IN-1:0]  rise;
    logic [DEB_W-1:0] deb_cnt [N_IN];

    logic             dp_vld;
    logic             dp_write;
    logic             dp_word;
    logic [5:0]       dp_addr;
    logic             wr_en;
    logic [N_OUT-1:0] wd_out;
    logic [N_IN-1:0]  wd_in;

    logic [N_IN-1:0]  irq_en;
    logic [N_IN-1:0]  irq_stat;
    logic [N_IN-1:0]  stat_clr;
    logic [N_IN-1:0]  irq_src;
    logic             unused_bits;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Only HADDR[7:2], HTRANS[1] and the low HWDATA bits carry meaning here.
    assign unused_bits = ^{HADDR, HTRANS[0], HWDATA};

    // Two-flop synchroniser for the asynchronous button pins
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            stable <= '0;
            for (int i = 0; i < N_IN; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (deb_cnt[i] == DEB_MAX) begin
                        stable[i]  <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Delayed copy of the debounced level for rising-edge detection
    always_ff @(posedge HCLK) begin
        if (!HRESETn) stable_d <= '0;
        else          stable_d <= stable;
    end

    assign rise = stable & ~stable_d;

    // Address phase capture; a reset drops any pending data phase
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            dp_word  <= 1'b0;
            dp_addr  <= '0;
        end else if (HSEL && HREADY && HTRANS[1]) begin
            dp_vld   <= 1'b1;
            dp_write <= HWRITE;
            dp_word  <= (HSIZE == 3'b010);
            dp_addr  <= HADDR[7:2];
        end else begin
            dp_vld   <= 1'b0;
        end
    end

    assign wr_en    = dp_vld && dp_write && dp_word;
    assign wd_out   = HWDATA[N_OUT-1:0];
    assign wd_in    = HWDATA[N_IN-1:0];
    assign stat_clr = (wr_en && dp_addr == A_STAT) ? wd_in : '0;

    // Output register with direct, set, clear and toggle write ports
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            gpio_out <= '0;
        end else if (wr_en) begin
            case (dp_addr)
                A_OUT:   gpio_out <= wd_out;
                A_SET:   gpio_out <= gpio_out | wd_out;
                A_CLR:   gpio_out <= gpio_out & ~wd_out;
                A_TGL:   gpio_out <= gpio_out ^ wd_out;
                default: gpio_out <= gpio_out;
            endcase
        end
    end

    // Interrupt enable register
    always_ff @(posedge HCLK) begin
        if (!HRESETn)                         irq_en <= '0;
        else if (wr_en && dp_addr == A_EN)    irq_en <= wd_in;
    end

    // Sticky edge status; a rise in the clearing cycle keeps the bit set
    always_ff @(posedge HCLK) begin
        if (!HRESETn) irq_stat <= '0;
        else          irq_stat <= (irq_stat & ~stat_clr) | rise;
    end

`ifdef GPIO_LONGPRESS_EN
    localparam int            LW        = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_DONE = LW'(LONG_CYCLES);

    logic [LW-1:0]   hold_cnt [N_IN];
    logic [N_IN-1:0] long_hit;
    logic [N_IN-1:0] long_stat;
    logic [N_IN-1:0] long_clr;

    assign long_clr = (wr_en && dp_addr == A_LONG) ? wd_in : '0;

    // Hold counters run while pressed and park at LONG_DONE so each press fires once
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int i = 0; i < N_IN; i++) hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (!stable[i])                  hold_cnt[i] <= '0;
                else if (hold_cnt[i] != LONG_DONE) hold_cnt[i] <= hold_cnt[i] + LW'(1);
            end
        end
    end

    // Threshold hit for each channel in the cycle its counter reaches LONG_MAX
    always_comb begin
        long_hit = '0;
        for (int i = 0; i < N_IN; i++)
            long_hit[i] = stable[i] && (hold_cnt[i] == LONG_MAX);
    end

    // Sticky long-press status; a hit in the clearing cycle keeps the bit set
    always_ff @(posedge HCLK) begin
        if (!HRESETn) long_stat <= '0;
        else          long_stat <= (long_stat & ~long_clr) | long_hit;
    end

    assign irq_src = (irq_stat | long_stat) & irq_en;
`else
    assign irq_src = irq_stat & irq_en;
`endif

    // Registered level interrupt
    always_ff @(posedge HCLK) begin
        if (!HRESETn) irq <= 1'b0;
        else          irq <= |irq_src;
    end

    // Read mux on the captured data-phase address
    always_comb begin
        HRDATA = '0;
        if (dp_vld && !dp_write) begin
            case (dp_addr)
                A_IN:    HRDATA = 32'(stable);
                A_OUT:   HRDATA = 32'(gpio_out);
                A_EN:    HRDATA = 32'(irq_en);
                A_STAT:  HRDATA = 32'(irq_stat);
`ifdef GPIO_LONGPRESS_EN
                A_LONG:  HRDATA = 32'(long_stat);
`endif
                default: HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_gpio_ctrl.sv
// Directed bench for ahb_gpio_ctrl with short debounce and long-press thresholds.
// Bus inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Long-press vectors run only when GPIO_LONGPRESS_EN is defined for the build.
module tb_ahb_gpio_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [4:0]  gpio_in;
    logic [15:0] gpio_out;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] rd;

    ahb_gpio_ctrl #(
        .N_IN(5), .N_OUT(16), .DEB_CYCLES(4), .DEB_W(3), .LONG_CYCLES(10)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] sz, input logic [1:0] tr);
        HSEL = 1'b1; HTRANS = tr; HWRITE = 1'b1; HSIZE = sz; HADDR = a;
        tick(1);
        bus_idle();
        HWDATA = d;
        tick(1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ahb_write(a, d, 3'b010, 2'b10);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = a;
        tick(1);
        d = HRDATA;
        bus_idle();
    endtask

    // Leaves a read of address a permanently in flight so HRDATA tracks it every cycle
    task automatic hold_read(input logic [31:0] a);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = a;
        tick(1);
    endtask

    initial begin
        HRESETn = 1'b0; HREADY = 1'b1; HADDR = '0; HWDATA = '0;
        bus_idle();
        gpio_in = 5'h1F;

        // Reset
        tick(3);
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        check("rst_hresp", 32'(HRESP), 32'h0);
        HRESETn = 1'b1;
        gpio_in = 5'h00;
        tick(2);
        ahb_read(32'h00, rd);
        check("rst_in_read", rd, 32'h0);

        // Debounce: a 3-cycle glitch is rejected
        gpio_in[0] = 1'b1;
        tick(3);
        gpio_in[0] = 1'b0;
        tick(10);
        ahb_read(32'h00, rd);
        check("glitch_in", rd, 32'h0);
        ahb_read(32'h18, rd);
        check("glitch_stat", rd, 32'h0);

        // Debounce: a held level lands exactly 6 cycles after the edge
        hold_read(32'h00);
        gpio_in[0] = 1'b1;
        tick(5);
        check("deb_in_5cyc", HRDATA, 32'h0);
        tick(1);
        check("deb_in_6cyc", HRDATA, 32'h1);
        bus_idle();
        tick(2);
        ahb_read(32'h18, rd);
        check("deb_stat", rd, 32'h01);
        check("deb_irq_disabled", 32'(irq), 32'h0);
        wr(32'h18, 32'h01);
        ahb_read(32'h18, rd);
        check("stat_w1c", rd, 32'h0);

        // Output register operations
        wr(32'h04, 32'h00F0);
        wr(32'h08, 32'h0003);
        wr(32'h0C, 32'h0010);
        wr(32'h10, 32'h8001);
        check("out_ops", 32'(gpio_out), 32'h80E2);
        ahb_read(32'h04, rd);
        check("out_read", rd, 32'h80E2);
        ahb_read(32'h08, rd);
        check("wo_reads_zero", rd, 32'h0);
        // Back-to-back write then read of the same register
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010; HADDR = 32'h04;
        tick(1);
        HWDATA = 32'h5A5A; HWRITE = 1'b0;
        tick(1);
        check("b2b_read", HRDATA, 32'h5A5A);
        bus_idle();
        wr(32'h04, 32'h80E2);

        // Interrupt on channel 2
        wr(32'h14, 32'h04);
        ahb_read(32'h14, rd);
        check("irq_en_read", rd, 32'h04);
        hold_read(32'h18);
        gpio_in[2] = 1'b1;
        tick(7);
        check("irq_stat_set", HRDATA, 32'h04);
        check("irq_not_yet", 32'(irq), 32'h0);
        tick(1);
        check("irq_asserted", 32'(irq), 32'h1);
        bus_idle();
        wr(32'h18, 32'h04);
        tick(1);
        check("irq_cleared", 32'(irq), 32'h0);
        // Set and clear of the same bit in one cycle: set wins
        gpio_in[2] = 1'b0;
        tick(10);
        gpio_in[2] = 1'b1;
        tick(5);
        wr(32'h18, 32'h04);
        ahb_read(32'h18, rd);
        check("stat_set_wins", rd, 32'h04);
        check("irq_held", 32'(irq), 32'h1);
        wr(32'h18, 32'h04);
        wr(32'h14, 32'h00);

        // Bus corner cases
        ahb_write(32'h04, 32'hFFFF, 3'b000, 2'b10);
        check("byte_write_ignored", 32'(gpio_out), 32'h80E2);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h3C;
        tick(1);
        check("unmapped_read", HRDATA, 32'h0);
        check("unmapped_hresp", 32'(HRESP), 32'h0);
        bus_idle();
        ahb_write(32'h04, 32'h1111, 3'b010, 2'b00);
        check("idle_no_write", 32'(gpio_out), 32'h80E2);
        wr(32'h20, 32'hFFFF);
        check("unmapped_write", 32'(gpio_out), 32'h80E2);
        ahb_read(32'h1C, rd);
        check("long_reg_idle", rd, 32'h0);

        // Reset during a write data phase
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010; HADDR = 32'h04;
        tick(1);
        bus_idle();
        HWDATA = 32'h00FF;
        HRESETn = 1'b0;
        tick(1);
        HRESETn = 1'b1;
        tick(1);
        check("rst_mid_write", 32'(gpio_out), 32'h0);
        check("rst_mid_irq", 32'(irq), 32'h0);
        ahb_read(32'h14, rd);
        check("rst_mid_en", rd, 32'h0);

`ifdef GPIO_LONGPRESS_EN
        gpio_in = 5'h00;
        tick(10);
        wr(32'h1C, 32'h1F);
        gpio_in[1] = 1'b1;
        tick(26);
        ahb_read(32'h1C, rd);
        check("long_set", rd, 32'h02);
        wr(32'h1C, 32'h02);
        tick(20);
        ahb_read(32'h1C, rd);
        check("long_once", rd, 32'h0);
        gpio_in[1] = 1'b0;
        tick(10);
        hold_read(32'h1C);
        gpio_in[1] = 1'b1;
        tick(15);
        check("long_again_early", HRDATA, 32'h0);
        tick(1);
        check("long_again", HRDATA, 32'h02);
        bus_idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
